// File: rtl/move_sequencer_pkg.sv
// Shared widths, the "no en-passant column" code and the sequencer state encoding.
package move_sequencer_pkg;

    localparam int PIECE_BITS    = 4;
    localparam int MAX_POSITIONS = 256;

    // Bit 3 set means no en-passant column is available.
    localparam logic [3:0] EP_NONE = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ROOT_EVAL = 4'd1,
        ST_ROOT_WAIT = 4'd2,
        ST_GEN       = 4'd3,
        ST_GEN_WAIT  = 4'd4,
        ST_FETCH     = 4'd5,
        ST_EVAL      = 4'd6,
        ST_EVAL_WAIT = 4'd7,
        ST_EMIT      = 4'd8,
        ST_NEXT      = 4'd9,
        ST_CLEAR     = 4'd10,
        ST_DONE      = 4'd11
    } mseq_state_e;

endpackage

// File: rtl/move_sequencer.sv
// One-ply search sequencer: evaluates the root for check, generates children,
// filters out children that leave the mover in check, streams legal children.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; root is registered when start is seen
// ROOT_EVAL | evaluate strobe carrying the root position
// ROOT_WAIT | wait for evaluator; latch whether the mover is in check
// GEN       | generate strobe to the move generator
// GEN_WAIT  | wait for generation; latch child count
// FETCH     | select child idx, wait out the read latency, capture child
// EVAL      | evaluate strobe carrying the captured child
// EVAL_WAIT | wait for evaluator; child legal unless mover's king attacked
// EMIT      | present legal child until the consumer accepts it
// NEXT      | advance to the next child or finish the walk
// CLEAR     | clear strobe to the move generator
// DONE      | one-cycle done with count and mate/stalemate verdict
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int PIECE_WIDTH        = PIECE_BITS,
    parameter int BOARD_WIDTH        = PIECE_WIDTH * 64,
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
    parameter int READ_LATENCY       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BOARD_WIDTH-1:0]        board,
    input  logic                          white_to_move,
    input  logic [3:0]                    castle_mask,
    input  logic [3:0]                    en_passant_col,
    output logic                          busy,
    output logic                          am_board_valid,
    output logic [BOARD_WIDTH-1:0]        am_board,
    output logic                          am_white_to_move,
    output logic [3:0]                    am_castle_mask,
    output logic [3:0]                    am_en_passant_col,
    output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
    output logic                          am_clear_moves,
    input  logic                          am_moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
    input  logic [BOARD_WIDTH-1:0]        am_board_out,
    input  logic                          am_white_to_move_out,
    input  logic [3:0]                    am_castle_mask_out,
    input  logic [3:0]                    am_en_passant_col_out,
    output logic                          at_board_valid,
    output logic [BOARD_WIDTH-1:0]        at_board,
    output logic                          at_white_to_move,
    input  logic                          at_done,
    input  logic                          at_white_in_check,
    input  logic                          at_black_in_check,
    output logic                          legal_valid,
    input  logic                          legal_ready,
    output logic [BOARD_WIDTH-1:0]        legal_board,
    output logic                          legal_white_to_move,
    output logic [3:0]                    legal_castle_mask,
    output logic [3:0]                    legal_en_passant_col,
    output logic                          done,
    output logic [MAX_POSITIONS_LOG2-1:0] legal_count,
    output logic                          checkmate,
    output logic                          stalemate
);

    localparam int WAIT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [MAX_POSITIONS_LOG2-1:0] ONE = MAX_POSITIONS_LOG2'(1);

    mseq_state_e                   state_q, state_d;
    logic [BOARD_WIDTH-1:0]        am_board_q, am_board_d;
    logic                          am_wtm_q, am_wtm_d;
    logic [3:0]                    am_castle_q, am_castle_d;
    logic [3:0]                    am_ep_q, am_ep_d;
    logic [BOARD_WIDTH-1:0]        at_board_q, at_board_d;
    logic                          at_wtm_q, at_wtm_d;
    logic [BOARD_WIDTH-1:0]        child_board_q, child_board_d;
    logic                          child_wtm_q, child_wtm_d;
    logic [3:0]                    child_castle_q, child_castle_d;
    logic [3:0]                    child_ep_q, child_ep_d;
    logic [MAX_POSITIONS_LOG2-1:0] idx_q, idx_d;
    logic [MAX_POSITIONS_LOG2-1:0] count_q, count_d;
    logic [MAX_POSITIONS_LOG2-1:0] legal_count_q, legal_count_d;
    logic [WAIT_W-1:0]             wait_q, wait_d;
    logic                          root_in_check_q, root_in_check_d;
    logic                          mover_in_check;

    // The mover is always the root side, for the root and for every child.
    assign mover_in_check = am_wtm_q ? at_white_in_check : at_black_in_check;

    // State and datapath registers; e.p. column resets to "none".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            am_board_q      <= '0;
            am_wtm_q        <= 1'b0;
            am_castle_q     <= 4'd0;
            am_ep_q         <= EP_NONE;
            at_board_q      <= '0;
            at_wtm_q        <= 1'b0;
            child_board_q   <= '0;
            child_wtm_q     <= 1'b0;
            child_castle_q  <= 4'd0;
            child_ep_q      <= 4'd0;
            idx_q           <= '0;
            count_q         <= '0;
            legal_count_q   <= '0;
            wait_q          <= '0;
            root_in_check_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            am_board_q      <= am_board_d;
            am_wtm_q        <= am_wtm_d;
            am_castle_q     <= am_castle_d;
            am_ep_q         <= am_ep_d;
            at_board_q      <= at_board_d;
            at_wtm_q        <= at_wtm_d;
            child_board_q   <= child_board_d;
            child_wtm_q     <= child_wtm_d;
            child_castle_q  <= child_castle_d;
            child_ep_q      <= child_ep_d;
            idx_q           <= idx_d;
            count_q         <= count_d;
            legal_count_q   <= legal_count_d;
            wait_q          <= wait_d;
            root_in_check_q <= root_in_check_d;
        end
    end

    // Next-state and datapath updates for the ply walk.
    always_comb begin
        state_d         = state_q;
        am_board_d      = am_board_q;
        am_wtm_d        = am_wtm_q;
        am_castle_d     = am_castle_q;
        am_ep_d         = am_ep_q;
        at_board_d      = at_board_q;
        at_wtm_d        = at_wtm_q;
        child_board_d   = child_board_q;
        child_wtm_d     = child_wtm_q;
        child_castle_d  = child_castle_q;
        child_ep_d      = child_ep_q;
        idx_d           = idx_q;
        count_d         = count_q;
        legal_count_d   = legal_count_q;
        wait_d          = wait_q;
        root_in_check_d = root_in_check_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    am_board_d    = board;
                    am_wtm_d      = white_to_move;
                    am_castle_d   = castle_mask;
                    am_ep_d       = en_passant_col;
                    at_board_d    = board;
                    at_wtm_d      = white_to_move;
                    legal_count_d = '0;
                    idx_d         = '0;
                    state_d       = ST_ROOT_EVAL;
                end
            end
            ST_ROOT_EVAL: state_d = ST_ROOT_WAIT;
            ST_ROOT_WAIT: begin
                if (at_done) begin
                    root_in_check_d = mover_in_check;
                    state_d         = ST_GEN;
                end
            end
            ST_GEN: state_d = ST_GEN_WAIT;
            ST_GEN_WAIT: begin
                if (am_moves_ready) begin
                    count_d = am_move_count;
                    if (am_move_count == '0) begin
                        state_d = ST_CLEAR;
                    end else begin
                        idx_d   = '0;
                        wait_d  = WAIT_W'(READ_LATENCY);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (wait_q == '0) begin
                    child_board_d  = am_board_out;
                    child_wtm_d    = am_white_to_move_out;
                    child_castle_d = am_castle_mask_out;
                    child_ep_d     = am_en_passant_col_out;
                    at_board_d     = am_board_out;
                    at_wtm_d       = am_white_to_move_out;
                    state_d        = ST_EVAL;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_EVAL: state_d = ST_EVAL_WAIT;
            ST_EVAL_WAIT: begin
                if (at_done) begin
                    state_d = mover_in_check ? ST_NEXT : ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (legal_ready) begin
                    legal_count_d = legal_count_q + ONE;
                    state_d       = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == count_q - ONE) begin
                    state_d = ST_CLEAR;
                end else begin
                    idx_d   = idx_q + ONE;
                    wait_d  = WAIT_W'(READ_LATENCY);
                    state_d = ST_FETCH;
                end
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy                 = (state_q != ST_IDLE);
    assign am_board_valid       = (state_q == ST_GEN);
    assign am_board             = am_board_q;
    assign am_white_to_move     = am_wtm_q;
    assign am_castle_mask       = am_castle_q;
    assign am_en_passant_col    = am_ep_q;
    assign am_move_index        = idx_q;
    assign am_clear_moves       = (state_q == ST_CLEAR);
    assign at_board_valid       = (state_q == ST_ROOT_EVAL) || (state_q == ST_EVAL);
    assign at_board             = at_board_q;
    assign at_white_to_move     = at_wtm_q;
    assign legal_valid          = (state_q == ST_EMIT);
    assign legal_board          = child_board_q;
    assign legal_white_to_move  = child_wtm_q;
    assign legal_castle_mask    = child_castle_q;
    assign legal_en_passant_col = child_ep_q;
    assign done                 = (state_q == ST_DONE);
    assign legal_count          = legal_count_q;
    assign checkmate            = done && (legal_count_q == '0) && root_in_check_q;
    assign stalemate            = done && (legal_count_q == '0) && !root_in_check_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with behavioural generator/evaluator models.
module tb_move_sequencer;

    localparam int BW = 256;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] board = '0;
    logic          white_to_move = 1'b0;
    logic [3:0]    castle_mask = 4'd0;
    logic [3:0]    en_passant_col = 4'b1000;
    logic          busy;
    logic          am_board_valid;
    logic [BW-1:0] am_board;
    logic          am_white_to_move;
    logic [3:0]    am_castle_mask;
    logic [3:0]    am_en_passant_col;
    logic [CW-1:0] am_move_index;
    logic          am_clear_moves;
    logic          am_moves_ready = 1'b0;
    logic [CW-1:0] am_move_count = '0;
    logic [BW-1:0] am_board_out = '0;
    logic          am_white_to_move_out = 1'b0;
    logic [3:0]    am_castle_mask_out = 4'd0;
    logic [3:0]    am_en_passant_col_out = 4'd0;
    logic          at_board_valid;
    logic [BW-1:0] at_board;
    logic          at_white_to_move;
    logic          at_done = 1'b0;
    logic          at_white_in_check = 1'b1;
    logic          at_black_in_check = 1'b1;
    logic          legal_valid;
    logic          legal_ready = 1'b0;
    logic [BW-1:0] legal_board;
    logic          legal_white_to_move;
    logic [3:0]    legal_castle_mask;
    logic [3:0]    legal_en_passant_col;
    logic          done;
    logic [CW-1:0] legal_count;
    logic          checkmate;
    logic          stalemate;

    move_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .board(board),
        .white_to_move(white_to_move), .castle_mask(castle_mask),
        .en_passant_col(en_passant_col), .busy(busy),
        .am_board_valid(am_board_valid), .am_board(am_board),
        .am_white_to_move(am_white_to_move), .am_castle_mask(am_castle_mask),
        .am_en_passant_col(am_en_passant_col), .am_move_index(am_move_index),
        .am_clear_moves(am_clear_moves), .am_moves_ready(am_moves_ready),
        .am_move_count(am_move_count), .am_board_out(am_board_out),
        .am_white_to_move_out(am_white_to_move_out),
        .am_castle_mask_out(am_castle_mask_out),
        .am_en_passant_col_out(am_en_passant_col_out),
        .at_board_valid(at_board_valid), .at_board(at_board),
        .at_white_to_move(at_white_to_move), .at_done(at_done),
        .at_white_in_check(at_white_in_check), .at_black_in_check(at_black_in_check),
        .legal_valid(legal_valid), .legal_ready(legal_ready),
        .legal_board(legal_board), .legal_white_to_move(legal_white_to_move),
        .legal_castle_mask(legal_castle_mask), .legal_en_passant_col(legal_en_passant_col),
        .done(done), .legal_count(legal_count), .checkmate(checkmate), .stalemate(stalemate)
    );

    always #5 clk = ~clk;

    // Scenario configuration, written only by the main sequence.
    logic [15:0] salt = 16'd0;
    int          n_children = 0;
    logic        root_wtm = 1'b1;
    logic        root_wic = 1'b0;
    logic        root_bic = 1'b0;
    logic [31:0] child_wic = '0;
    logic [31:0] child_bic = '0;
    int          stall = 0;
    int          eval_lat = 2;
    int          gen_lat = 3;

    int checks = 0;
    int failures = 0;

    function automatic logic [BW-1:0] child_brd(input logic [15:0] s, input int i);
        return {8{s, 16'(i)}};
    endfunction

    function automatic logic [BW-1:0] root_brd(input logic [15:0] s);
        return {8{16'hF00D, s}};
    endfunction

    // Child store: index registered once, data registered again (2-cycle read).
    logic [CW-1:0] rd1 = '0;
    always @(posedge clk) begin
        rd1                   <= am_move_index;
        am_board_out          <= child_brd(salt, int'(rd1));
        am_white_to_move_out  <= ~root_wtm;
        am_castle_mask_out    <= rd1[3:0];
        am_en_passant_col_out <= rd1[3:0] ^ 4'h5;
    end

    // Generator and evaluator models; check flags are 1 except on at_done.
    logic       gen_seen = 1'b0;
    int         ev_cnt = 0;
    int         gn_cnt = 0;
    logic       ev_root = 1'b0;
    logic [4:0] ev_idx = '0;
    always @(negedge clk) begin
        if (!busy) gen_seen = 1'b0;
        at_done = 1'b0;
        at_white_in_check = 1'b1;
        at_black_in_check = 1'b1;
        if (ev_cnt > 0) begin
            ev_cnt--;
            if (ev_cnt == 0) begin
                at_done = 1'b1;
                if (ev_root) begin
                    at_white_in_check = root_wic;
                    at_black_in_check = root_bic;
                end else begin
                    at_white_in_check = child_wic[ev_idx];
                    at_black_in_check = child_bic[ev_idx];
                end
            end
        end
        if (at_board_valid) begin
            ev_cnt  = eval_lat;
            ev_root = !gen_seen;
            ev_idx  = am_move_index[4:0];
        end
        am_moves_ready = 1'b0;
        if (gn_cnt > 0) begin
            gn_cnt--;
            if (gn_cnt == 0) begin
                am_moves_ready = 1'b1;
                am_move_count  = CW'(n_children);
            end
        end
        if (am_board_valid) begin
            gen_seen = 1'b1;
            gn_cnt   = gen_lat;
        end
    end

    // Pulse counters, consumer with programmable stall, payload stability watch.
    int            done_cnt = 0, clear_cnt = 0, gen_pulses = 0, atv_cnt = 0;
    int            stab_err = 0, stall_obs = 0, stall_cnt = 0;
    logic          last_cm = 1'b0, last_sm = 1'b0;
    logic [CW-1:0] last_lc = '0;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_board = '0;
    logic [BW-1:0] emitted[$];
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_lc = legal_count;
            last_cm = checkmate;
            last_sm = stalemate;
        end
        if (am_clear_moves) clear_cnt++;
        if (am_board_valid) gen_pulses++;
        if (at_board_valid) atv_cnt++;
        if (prev_stall) begin
            if (!legal_valid || legal_board !== prev_board) stab_err++;
            else stall_obs++;
        end
        if (legal_valid) begin
            if (stall_cnt >= stall) begin
                legal_ready = 1'b1;
                emitted.push_back(legal_board);
                stall_cnt = 0;
            end else begin
                legal_ready = 1'b0;
                stall_cnt++;
            end
        end else begin
            legal_ready = 1'b0;
        end
        prev_stall = legal_valid && !legal_ready && !reset;
        prev_board = legal_board;
    end

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_ply(input logic [15:0] s, input logic wtm);
        @(negedge clk);
        board          = root_brd(s);
        white_to_move  = wtm;
        castle_mask    = 4'b1111;
        en_passant_col = 4'b1000;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_done_seen"}, BW'(done_cnt != base), BW'(1));
    endtask

    // One ply: configure models, start (optionally a second ignored start), check results.
    task automatic run_case(input string nm, input logic [15:0] s, input int n, input logic wtm,
                            input logic rwic, input logic rbic, input logic [31:0] cw,
                            input logic [31:0] cb, input int st, input bit dbl,
                            input int exp_cnt, input logic exp_cm, input logic exp_sm,
                            input logic [31:0] exp_mask, input int exp_stall_obs);
        int b_done, b_clear, b_gen, b_atv, b_emit, b_stab, b_sobs, k;
        salt = s; n_children = n; root_wtm = wtm; root_wic = rwic; root_bic = rbic;
        child_wic = cw; child_bic = cb; stall = st;
        b_done = done_cnt; b_clear = clear_cnt; b_gen = gen_pulses; b_atv = atv_cnt;
        b_emit = emitted.size(); b_stab = stab_err; b_sobs = stall_obs;
        start_ply(s, wtm);
        if (dbl) begin
            repeat (3) @(negedge clk);
            board = root_brd(16'hDEAD);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(nm, b_done, 3000);
        repeat (20) @(negedge clk);
        #1;
        chk({nm, "_done_pulses"}, BW'(done_cnt - b_done), BW'(1));
        chk({nm, "_clear_pulses"}, BW'(clear_cnt - b_clear), BW'(1));
        chk({nm, "_gen_pulses"}, BW'(gen_pulses - b_gen), BW'(1));
        chk({nm, "_eval_pulses"}, BW'(atv_cnt - b_atv), BW'(1 + n));
        chk({nm, "_legal_count"}, BW'(last_lc), BW'(exp_cnt));
        chk({nm, "_count_held"}, BW'(legal_count), BW'(exp_cnt));
        chk({nm, "_checkmate"}, BW'(last_cm), BW'(exp_cm));
        chk({nm, "_stalemate"}, BW'(last_sm), BW'(exp_sm));
        chk({nm, "_emitted"}, BW'(emitted.size() - b_emit), BW'(exp_cnt));
        chk({nm, "_root_held"}, am_board, root_brd(s));
        chk({nm, "_busy_low"}, BW'(busy), BW'(0));
        chk({nm, "_stability"}, BW'(stab_err - b_stab), BW'(0));
        chk({nm, "_stall_cycles"}, BW'(stall_obs - b_sobs), BW'(exp_stall_obs));
        k = b_emit;
        for (int i = 0; i < n; i++) begin
            if (exp_mask[i] && k < emitted.size()) begin
                chk($sformatf("%s_child%0d", nm, i), emitted[k], child_brd(s, i));
                k++;
            end
        end
        if (n > 0) begin
            chk({nm, "_last_castle"}, BW'(legal_castle_mask), BW'(4'(n - 1)));
            chk({nm, "_last_ep"}, BW'(legal_en_passant_col), BW'(4'(n - 1) ^ 4'h5));
        end
    endtask

    initial begin
        int b_done, n;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_done", BW'(done), BW'(0));
        chk("rst_ep", BW'(am_en_passant_col), BW'(4'b1000));
        chk("rst_count", BW'(legal_count), BW'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Ka1 Rb2 vs Kb8 Rh2 Qh8: children 1,4 expose the white king; black flags ignored.
        run_case("rook", 16'h0001, 6, 1'b1, 1'b0, 1'b1, 32'b010010, 32'b000101,
                 0, 1'b0, 4, 1'b0, 1'b0, 32'b101101, 0);
        // Back-rank mate: root in check, every child leaves the king attacked.
        run_case("mate", 16'h0002, 3, 1'b1, 1'b1, 1'b0, 32'b111, 32'b000,
                 0, 1'b0, 0, 1'b1, 1'b0, 32'b0, 0);
        // Stalemate: root not in check, no legal child.
        run_case("stale", 16'h0003, 2, 1'b1, 1'b0, 1'b1, 32'b11, 32'b00,
                 0, 1'b0, 0, 1'b0, 1'b1, 32'b0, 0);
        // Initial position: 20 legal children, consumer stalls 5 cycles on each.
        run_case("init", 16'h0004, 20, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFF,
                 5, 1'b0, 20, 1'b0, 1'b0, 32'hFFFFF, 100);
        // Black to move: only black check flags decide legality; extra start ignored.
        run_case("black", 16'h0005, 4, 1'b0, 1'b1, 1'b0, 32'b0110, 32'b1001,
                 2, 1'b1, 2, 1'b0, 1'b0, 32'b0110, 4);
        // No moves generated, black in check: checkmate straight from GEN_WAIT.
        run_case("nomoves", 16'h0006, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,
                 0, 1'b0, 0, 1'b1, 1'b0, 32'b0, 0);

        // Reset while the second child is under evaluation (one child already emitted).
        salt = 16'h0007; n_children = 3; root_wtm = 1'b1; root_wic = 1'b0; root_bic = 1'b0;
        child_wic = '0; child_bic = '0; stall = 0; eval_lat = 30;
        b_done = done_cnt;
        n = atv_cnt;
        start_ply(16'h0007, 1'b1);
        for (int i = 0; i < 400 && atv_cnt < n + 3; i++) @(negedge clk);
        chk("midrst_reached_eval", BW'(atv_cnt - n), BW'(3));
        repeat (3) @(negedge clk);
        chk("midrst_pre_count", BW'(legal_count), BW'(1));
        reset = 1'b1;
        #1;
        chk("midrst_outputs_zero",
            BW'(|{busy, am_board_valid, am_board, am_white_to_move, am_castle_mask,
                  am_move_index, am_clear_moves, at_board_valid, at_board, at_white_to_move,
                  legal_valid, legal_board, legal_white_to_move, legal_castle_mask,
                  legal_en_passant_col, done, legal_count, checkmate, stalemate}),
            BW'(0));
        chk("midrst_ep", BW'(am_en_passant_col), BW'(4'b1000));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("midrst_no_done", BW'(done_cnt - b_done), BW'(0));
        eval_lat = 2;
        run_case("afterrst", 16'h0008, 3, 1'b1, 1'b0, 1'b0, 32'b010, 32'b000,
                 1, 1'b0, 2, 1'b0, 1'b0, 32'b101, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Controller that sequences one ply of search over the shared move generator (all_moves) and attack evaluator (vchess). It takes a root position and launches move generation. It then walks every generated child, runs the attack evaluator on each to reject moves that leave the mover's king in check, and streams legal children out over a valid/ready interface. It finishes with a done pulse that carries the legal count and a mate/stalemate verdict.

Parameters:
PIECE_WIDTH, `PIECE_BITS, bits per square
BOARD_WIDTH, PIECE_WIDTH*64, packed board width
MAX_POSITIONS_LOG2, $clog2(`MAX_POSITIONS), move index/count width
READ_LATENCY, 2, cycles from am_move_index change to valid am_board_out/aux outputs

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  begin ply; sampled only in IDLE
board  in  BOARD_WIDTH  root position
white_to_move  in  1  root side to move
castle_mask  in  4  root castle rights
en_passant_col  in  4  root e.p. column (bit3=none)
busy  out  1  high from accepted start through done cycle
am_board_valid  out  1  1-cycle generate strobe to all_moves
am_board  out  BOARD_WIDTH  registered copy of root board
am_white_to_move  out  1  registered root side
am_castle_mask  out  4  registered root castle rights
am_en_passant_col  out  4  registered root e.p. column
am_move_index  out  MAX_POSITIONS_LOG2  child select
am_clear_moves  out  1  1-cycle clear strobe
am_moves_ready  in  1  generation complete
am_move_count  in  MAX_POSITIONS_LOG2  children generated
am_board_out  in  BOARD_WIDTH  selected child board
am_white_to_move_out  in  1  child side to move
am_castle_mask_out  in  4  child castle rights
am_en_passant_col_out  in  4  child e.p. column
at_board_valid  out  1  1-cycle evaluate strobe to vchess
at_board  out  BOARD_WIDTH  board under evaluation
at_white_to_move  out  1  side to move of evaluated board
at_done  in  1  vchess is_attacking_done
at_white_in_check  in  1  vchess result
at_black_in_check  in  1  vchess result
legal_valid  out  1  legal child presented
legal_ready  in  1  consumer accepts
legal_board  out  BOARD_WIDTH  legal child board
legal_white_to_move  out  1  legal child side to move
legal_castle_mask  out  4  legal child castle rights
legal_en_passant_col  out  4  legal child e.p. column
done  out  1  1-cycle ply-complete pulse
legal_count  out  MAX_POSITIONS_LOG2  legal children emitted; held until next start
checkmate  out  1  valid with done
stalemate  out  1  valid with done

Behaviour:
- Reset (async, active-high): all outputs 0, except am_en_passant_col=4'b1000. State returns to IDLE. Reset mid-ply abandons the ply; no done is issued.
- States: IDLE, ROOT_EVAL, ROOT_WAIT, GEN, GEN_WAIT, FETCH, EVAL, EVAL_WAIT, EMIT, NEXT, CLEAR, DONE.
- IDLE: on start, register the root onto am_* and at_*, set busy, clear legal_count and idx, go to ROOT_EVAL.
- ROOT_EVAL: pulse at_board_valid with the root; go to ROOT_WAIT.
- ROOT_WAIT: on at_done, latch root_in_check = white_to_move ? at_white_in_check : at_black_in_check; go to GEN.
- GEN: pulse am_board_valid; go to GEN_WAIT.
- GEN_WAIT: on am_moves_ready, latch am_move_count. If count==0, go to CLEAR; else idx=0 and go to FETCH.
- FETCH: drive am_move_index=idx and wait READ_LATENCY cycles. Then capture the child into a holding register, set at_board=child and at_white_to_move=child side, and go to EVAL.
- EVAL: pulse at_board_valid; go to EVAL_WAIT.
- EVAL_WAIT: on at_done, the child is illegal iff (root white_to_move ? at_white_in_check : at_black_in_check). Legal goes to EMIT; illegal goes to NEXT.
- EMIT: assert legal_valid with the held child. Payload stays stable while valid && !ready. On valid && ready: legal_count+1, go to NEXT. Valid never drops without ready.
- NEXT: if idx==count-1, go to CLEAR; else idx+1, go to FETCH.
- CLEAR: pulse am_clear_moves; go to DONE.
- DONE: pulse done. checkmate = (legal_count==0)&&root_in_check; stalemate = (legal_count==0)&&!root_in_check. Clear busy, go to IDLE.
- start while busy is ignored.
- at_done or am_moves_ready outside their wait states is ignored.
- Exactly one strobe is in flight on each shared unit at a time.
- Counter width is MAX_POSITIONS_LOG2. am_move_count == `MAX_POSITIONS-1 is the largest count; idx never wraps.
- Minimum latency start→done (no moves) = 6 cycles + evaluator latency + generator latency.

Decomposition:
- vchess.vh supplies piece codes, `PIECE_BITS and `MAX_POSITIONS; add the state encoding localparams there as `MSEQ_* defines.
- No sub-module; a single FSM plus a child holding register.

Test Plan:
- White Ka1, Rb2; black Kb8, Rh2, Qh8; white to move; start → every emitted child has at_white_in_check=0; done with legal_count equal to the number of legal children (bench reference), checkmate=0, stalemate=0.
- Back-rank mate (white Kh1, pawns g2/h2; black Re1), white to move → zero legal_valid; done with legal_count=0, checkmate=1.
- Stalemate (white Ka1; black Qb3, Kc3), white to move → legal_count=0, stalemate=1, checkmate=0.
- Initial position; legal_ready held low 5 cycles per child → legal_board stable while stalled; legal_count=20; exactly one am_clear_moves pulse before done.
- Assert reset mid-EVAL_WAIT → all outputs zero the same cycle; start afterwards completes normally.
- start pulsed while busy → ignored; exactly one done per accepted start.
